// File: rtl/gpio_debounce.sv
// gpio_debounce: conditions raw board inputs for the demo system's gp_i port.
// Each bit passes through a 2-flop synchroniser and then an independent
// counter-based debouncer. The outputs are the clean level and registered
// single-cycle rise/fall pulses, all in the clk_sys domain.
module gpio_debounce #(
  parameter int unsigned      Width          = 5,
  parameter int unsigned      DebounceCycles = 50000,
  parameter logic [Width-1:0] ResetValue     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] raw_i,
  output logic [Width-1:0] in_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  localparam int unsigned    CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [Width-1:0]           sync1;
  logic [Width-1:0]           sync2;
  logic [Width-1:0][CntW-1:0] cnt_q;
  logic [Width-1:0][CntW-1:0] cnt_d;
  logic [Width-1:0]           in_d;
  logic [Width-1:0]           rise_d;
  logic [Width-1:0]           fall_d;

  // Two-flop synchroniser for the asynchronous pin levels.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync1 <= ResetValue;
      sync2 <= ResetValue;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce decision: count consecutive mismatches, accept on the last one.
  always_comb begin
    in_d   = in_o;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (sync2[i] == in_o[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        cnt_d[i]  = '0;
        in_d[i]   = sync2[i];
        rise_d[i] = sync2[i];
        fall_d[i] = ~sync2[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  // Register the level, counters and pulses; changed_o is derived from the
  // next-cycle pulses so it lines up with rise_o/fall_o.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      cnt_q     <= '0;
      in_o      <= ResetValue;
      rise_o    <= '0;
      fall_o    <= '0;
      changed_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      in_o      <= in_d;
      rise_o    <= rise_d;
      fall_o    <= fall_d;
      changed_o <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Self-checking bench for gpio_debounce (Width=5, DebounceCycles=4, ResetValue=0).
// A reference model built on a sliding window of synchronised samples
// predicts the outputs after every clock edge; a monitor compares them.
module tb_gpio_debounce;

  localparam int unsigned W = 5;
  localparam int unsigned D = 4;

  typedef struct packed {
    logic [W-1:0] in_v;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw = '1;
  logic [W-1:0] in_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic         changed_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t exp_q[$];

  // Model state: delay line for the synchroniser and the history of
  // synchronised samples seen since the last reset.
  logic [W-1:0] m_s1 = '0;
  logic [W-1:0] m_s2 = '0;
  logic [W-1:0] m_in = '0;
  logic [W-1:0] hist[$];

  gpio_debounce #(
    .Width(W),
    .DebounceCycles(D),
    .ResetValue('0)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_i(rst),
    .raw_i(raw),
    .in_o(in_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .changed_o(changed_o)
  );

  always #5 clk = ~clk;

  // A bit flips once the last D synchronised samples all disagree with its level.
  task automatic model_step(input logic r, input logic [W-1:0] rv);
    exp_t e;
    logic [W-1:0] acc;
    logic all_diff;
    acc = '0;
    if (r) begin
      m_s1 = '0;
      m_s2 = '0;
      m_in = '0;
      hist.delete();
      e.in_v = '0;
      e.rise = '0;
      e.fall = '0;
      e.chg  = 1'b0;
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++)
            if (hist[k][b] == m_in[b]) all_diff = 1'b0;
          acc[b] = all_diff;
        end
      end
      m_in   = m_in ^ acc;
      e.in_v = m_in;
      e.rise = acc & m_in;
      e.fall = acc & ~m_in;
      e.chg  = |acc;
      m_s2   = m_s1;
      m_s1   = rv;
    end
    exp_q.push_back(e);
  endtask

  // Stimulus side of the scoreboard: predict the response to each edge.
  initial forever begin
    @(posedge clk);
    model_step(rst, raw);
  end

  // Monitor: every cycle the DUT presents a new output word; compare it.
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({in_o, rise_o, fall_o, changed_o} !== e) begin
        fails++;
        $display("FAIL outputs cyc %0d: got in=%b rise=%b fall=%b chg=%b, want in=%b rise=%b fall=%b chg=%b",
                 cyc, in_o, rise_o, fall_o, changed_o, e.in_v, e.rise, e.fall, e.chg);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  task automatic hold(input logic [W-1:0] v, input int n);
    raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_in(input logic [W-1:0] want, input string what);
    tests++;
    if (in_o !== want) begin
      fails++;
      $display("FAIL %s: got in=%b, want in=%b", what, in_o, want);
    end
  endtask

  initial begin
    // Reset with all raw inputs high; release and let them debounce.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(5'b11111, 12);
    expect_in(5'b11111, "reset release settle");
    hold(5'b00000, 12);
    expect_in(5'b00000, "all low settle");
    // Clean change on bit 0.
    hold(5'b00001, 10);
    expect_in(5'b00001, "clean change bit0");
    // Glitch train on bit 2: high periods shorter than D.
    for (int n = 0; n < 10; n++) begin
      hold(5'b00101, 3);
      hold(5'b00001, 2);
    end
    hold(5'b00001, 6);
    expect_in(5'b00001, "glitch rejection bit2");
    // Release edge on bit 4.
    hold(5'b10001, 10);
    expect_in(5'b10001, "bit4 high");
    hold(5'b00001, 10);
    expect_in(5'b00001, "bit4 release");
    // Bits 1 and 3 together, bit 0 two cycles later.
    hold(5'b01011, 2);
    hold(5'b01010, 12);
    expect_in(5'b01010, "independence settle");
    // Mid-count reset.
    hold(5'b01011, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(5'b01011, 14);
    expect_in(5'b01011, "mid-count reset settle");
    // Randomised activity, including occasional resets and short glitches.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      hold(W'($urandom), int'($urandom_range(1, 7)));
    end
    rst = 1'b0;
    hold(raw, 12);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
